gcd_stein: RTL and testbench
============================

// Module: gcd_stein
// PURPOSE
//  Multi-cycle binary (Stein) GCD engine. It is the responder side of the ld/rdy operand handshake that our benches drive.
//  It accepts an operand pair (a, b) on a one-cycle ld pulse and iterates shift/subtract steps.
//  It returns gcd(a, b) on q with a one-cycle rdy pulse. It has no divider and no multiplier.
//  It sits between an operand source (testbench or host FSM) and a result consumer.
// PARAMETERS
//  W  8  operand/result width in bits; K counter width = $clog2(W)+1
// PORTS
//  clk    in   1  single clock; all state updates on posedge
//  reset  in   1  synchronous, active-high reset
//  a      in   W  operand A, sampled on an accepted ld
//  b      in   W  operand B, sampled on an accepted ld
//  ld     in   1  load strobe; accepted only in IDLE or DONE
//  q      out  W  result; valid while rdy=1; holds the last result until the next DONE
//  rdy    out  1  one-cycle pulse, result valid
//  busy   out  1  high in RUN; ld is ignored while busy=1
// BEHAVIOUR
//  Reset (sampled at posedge): state=IDLE, q=0, rdy=0, busy=0, internal ra/rb/k=0.
//  Reset overrides everything, including a computation in progress; that result is never delivered.
//  States:
//   IDLE: ld=1 -> ra<=a, rb<=b, k<=0, go RUN. Otherwise stay.
//   RUN: one step per cycle, priority in this order:
//    1. ra==0 -> q<=rb<<k, go DONE
//    2. rb==0 -> q<=ra<<k, go DONE
//    3. ra, rb both even -> ra>>=1, rb>>=1, k++
//    4. ra even -> ra>>=1
//    5. rb even -> rb>>=1
//    6. both odd, ra>=rb -> ra<=ra-rb; else rb<=rb-ra
//   DONE: rdy=1 for exactly this one cycle.
//    ld=1 -> load the new operands as in IDLE, go RUN (back-to-back issue, no bubble).
//    Otherwise go IDLE.
//  rdy and busy are decoded from the state register: rdy=(state==DONE), busy=(state==RUN).
//  Width rules:
//   - Shifts are logical.
//   - Subtraction is W-bit unsigned and never underflows, because of the compare.
//   - q = operand<<k never exceeds the original operand, so it fits in W bits.
//  Special values: gcd(0,0)=0; gcd(0,x)=x; gcd(x,0)=x.
//  Latency: ld accepted at edge N; RUN occupies edges N+1..N+S, where S is the number of steps.
//   - rdy is high in the cycle after edge N+S.
//   - Minimum 1 step (a zero operand); maximum 3W+1 steps.
//  ld while busy: ignored. Operands, k and the result are unaffected; the source must wait for rdy.
//  a and b are only sampled on an accepted ld; changes at any other time have no effect.
// TESTING
//  1. reset held 3 cycles -> q=0, rdy=0, busy=0; reset released with ld=0 -> stays IDLE.
//  2. ld with a=48, b=18 -> busy high, then exactly one rdy pulse with q=6; q still 6 afterwards.
//  3. (0,0)->0; (0,35)->35; (200,0)->200; each rdy arrives 2 cycles after the ld edge.
//  4. (128,64)->64 (exercises k=6); (255,255)->255; (1,255)->1; (97,89)->1 (coprime primes).
//  5. Back-to-back: new ld driven in every rdy cycle for 100 random pairs.
//     -> 100 rdy pulses, results match a reference gcd in order, no extra or missing pulses.
//     Every latency is <= 3W+2 cycles.
//  6. ld=1 with (9,6) mid-RUN of (48,18) -> ignored, q=6.
//     Reset asserted mid-RUN -> next cycle IDLE, no rdy; a following ld (21,14) -> q=7.

Source files
------------

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine: accepts an operand pair on a ld pulse, runs one
// shift/subtract step per cycle and returns gcd(a, b) on q with a one-cycle rdy.
module gcd_stein #(
   parameter int W = 8,
   parameter int K = $clog2(W) + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ld,
   output logic [W-1:0] q,
   output logic         rdy,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   ra_q, ra_d;
   logic [W-1:0]   rb_q, rb_d;
   logic [K-1:0]   k_q, k_d;
   logic [W-1:0]   res_q, res_d;

   logic           ra_even, rb_even;
   logic           ra_ge_rb;

   assign ra_even  = ~ra_q[0];
   assign rb_even  = ~rb_q[0];
   assign ra_ge_rb = (ra_q >= rb_q);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         k_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         k_q     <= k_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      k_d     = k_q;
      res_d   = res_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (ld) begin
               ra_d    = a;
               rb_d    = b;
               k_d     = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            if (ra_q == '0) begin
               res_d   = rb_q << k_q;
               state_d = S_DONE;
            end else if (rb_q == '0) begin
               res_d   = ra_q << k_q;
               state_d = S_DONE;
            end else if (ra_even && rb_even) begin
               ra_d = ra_q >> 1;
               rb_d = rb_q >> 1;
               k_d  = k_q + K'(1);
            end else if (ra_even) begin
               ra_d = ra_q >> 1;
            end else if (rb_even) begin
               rb_d = rb_q >> 1;
            end else if (ra_ge_rb) begin
               // Both odd: the compare guarantees the difference cannot wrap.
               ra_d = ra_q - rb_q;
            end else begin
               rb_d = rb_q - ra_q;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign q    = res_q;
   assign rdy  = (state_q == S_DONE);
   assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein: directed corner cases plus a back-to-back
// random run scored against a Euclid reference model.
module tb_gcd_stein;

   localparam int W       = 8;
   localparam int MAX_LAT = 3 * W + 2;
   localparam int TIMEOUT = MAX_LAT + 10;

   logic         clk;
   logic         reset;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ld;
   logic [W-1:0] q;
   logic         rdy;
   logic         busy;

   int checks;
   int failures;
   int rdy_cnt;
   int exp_pulses;

   gcd_stein #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .ld    (ld),
      .q     (q),
      .rdy   (rdy),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && rdy === 1'b1) rdy_cnt++;
   end

   function automatic int ref_gcd(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issues one operand pair and waits for rdy; returns the cycle count from
   // the accepting edge (inclusive) to the first cycle with rdy high.
   task automatic run_op(input int opa, input int opb, input int prev_q,
                         input string tag, output int lat);
      int exp_q;
      exp_q = ref_gcd(opa, opb);
      a  = W'(opa);
      b  = W'(opb);
      ld = 1'b1;
      @(posedge clk);
      #1;
      ld = 1'b0;
      a  = W'($urandom);
      b  = W'($urandom);
      lat = 1;
      check({tag, "_busy"}, int'(busy), 1);
      check({tag, "_qhold"}, int'(q), prev_q);
      while (rdy !== 1'b1 && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      exp_pulses++;
      check({tag, "_rdy"}, int'(rdy), 1);
      check({tag, "_q"}, int'(q), exp_q);
      check({tag, "_lat_bound"}, int'(lat <= MAX_LAT), 1);
   endtask

   initial begin
      int lat;
      int last_q;
      int ra, rb;

      checks     = 0;
      failures   = 0;
      rdy_cnt    = 0;
      exp_pulses = 0;
      reset      = 1'b1;
      ld         = 1'b0;
      a          = '0;
      b          = '0;

      // Reset held three cycles, then released with ld low.
      repeat (3) @(posedge clk);
      #1;
      check("rst_q", int'(q), 0);
      check("rst_rdy", int'(rdy), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;
      a = 8'hA5;
      b = 8'h3C;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", int'(busy), 0);
      check("idle_rdy", int'(rdy), 0);
      check("idle_q", int'(q), 0);

      // Basic operation and result hold after the pulse.
      run_op(48, 18, 0, "g48_18", lat);
      @(posedge clk);
      #1;
      check("g48_18_rdy_pulse", int'(rdy), 0);
      check("g48_18_idle", int'(busy), 0);
      check("g48_18_hold", int'(q), 6);

      // Zero operands finish in one step.
      run_op(0, 0, 6, "g0_0", lat);
      check("g0_0_lat", lat, 2);
      @(posedge clk);
      #1;
      run_op(0, 35, 0, "g0_35", lat);
      check("g0_35_lat", lat, 2);
      @(posedge clk);
      #1;
      run_op(200, 0, 35, "g200_0", lat);
      check("g200_0_lat", lat, 2);
      @(posedge clk);
      #1;

      // Directed corners: deep common power of two, equal, unit, coprime.
      run_op(128, 64, 200, "g128_64", lat);
      @(posedge clk);
      #1;
      run_op(255, 255, 64, "g255_255", lat);
      @(posedge clk);
      #1;
      run_op(1, 255, 255, "g1_255", lat);
      @(posedge clk);
      #1;
      run_op(97, 89, 1, "g97_89", lat);
      last_q = 1;

      // Back-to-back: each new ld is driven in the rdy cycle of the previous one.
      for (int i = 0; i < 100; i++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         run_op(ra, rb, last_q, "b2b", lat);
         last_q = ref_gcd(ra, rb);
      end
      @(posedge clk);
      #1;
      check("b2b_idle", int'(busy), 0);

      // ld while busy is ignored.
      a  = 8'd48;
      b  = 8'd18;
      ld = 1'b1;
      @(posedge clk);
      #1;
      ld = 1'b0;
      @(posedge clk);
      #1;
      check("ign_busy", int'(busy), 1);
      a  = 8'd9;
      b  = 8'd6;
      ld = 1'b1;
      @(posedge clk);
      #1;
      ld = 1'b0;
      lat = 0;
      while (rdy !== 1'b1 && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      exp_pulses++;
      check("ign_rdy", int'(rdy), 1);
      check("ign_q", int'(q), 6);
      @(posedge clk);
      #1;
      check("ign_single_pulse", int'(rdy), 0);

      // Reset in the middle of a computation drops it silently.
      a  = 8'd48;
      b  = 8'd18;
      ld = 1'b1;
      @(posedge clk);
      #1;
      ld = 1'b0;
      @(posedge clk);
      #1;
      check("mid_busy", int'(busy), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_rdy", int'(rdy), 0);
      check("mid_rst_q", int'(q), 0);
      repeat (TIMEOUT) @(posedge clk);
      #1;
      check("mid_rst_no_pulse", rdy_cnt, exp_pulses);
      run_op(21, 14, 0, "g21_14", lat);

      @(posedge clk);
      #1;
      check("pulse_count", rdy_cnt, exp_pulses);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
